// File: rtl/ahb_apb_pkg.sv
// Shared constants, FSM state type and address decode for the AHB-to-APB bridge.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWwait    = 3'd1,
    StRead     = 3'd2,
    StWrite    = 3'd3,
    StWritep   = 3'd4,
    StRenable  = 3'd5,
    StWenable  = 3'd6,
    StWenablep = 3'd7
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
  localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
  localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
  localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

  // One-hot peripheral select for an address; zero outside the map.
  function automatic logic [2:0] sel_decode(input logic [31:0] addr);
    logic [2:0] sel;
    sel = 3'b000;
    if (addr >= REGION0_BASE && addr <= REGION0_LIMIT) begin
      sel = 3'b001;
    end else if (addr >= REGION1_BASE && addr <= REGION1_LIMIT) begin
      sel = 3'b010;
    end else if (addr >= REGION2_BASE && addr <= REGION2_LIMIT) begin
      sel = 3'b100;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB side of the bridge: transfer qualification, select decode and the
// address/data/direction pipeline that lets writes overlap their data phase.
module ahb_slave_if
  import ahb_apb_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        valid,
  output logic [2:0]  selx,
  output logic [2:0]  selx1,
  output logic [2:0]  selx2,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwritereg
);

  // A transfer counts only when active, accepted by the bus and inside the map.
  always_comb begin
    valid = Hreadyin &&
            (Htrans == HTRANS_NONSEQ || Htrans == HTRANS_SEQ) &&
            (Haddr >= REGION0_BASE) && (Haddr <= REGION2_LIMIT);
    selx  = sel_decode(Haddr);
    selx1 = sel_decode(haddr1);
    selx2 = sel_decode(haddr2);
  end

  // Free-running pipeline, loaded every edge.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      haddr1    <= '0;
      haddr2    <= '0;
      hwdata1   <= '0;
      hwdata2   <= '0;
      hwritereg <= 1'b0;
    end else begin
      haddr1    <= Haddr;
      haddr2    <= haddr1;
      hwdata1   <= Hwdata;
      hwdata2   <= hwdata1;
      hwritereg <= Hwrite;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge top: sequencing FSM and registered APB/Hreadyout outputs.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Pwrite,
  output logic        Penable,
  output logic [2:0]  Pselx
);

  logic        valid;
  logic [2:0]  selx, selx1, selx2;
  logic [31:0] haddr1, haddr2, hwdata1;
  logic [31:0] unused_hwdata2;
  logic        hwritereg;

  state_e      state_q, state_d;
  logic [31:0] paddr_d, pwdata_d;
  logic        pwrite_d, penable_d, hreadyout_d;
  logic [2:0]  pselx_d;

  ahb_slave_if u_ahb_slave_if (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .valid     (valid),
    .selx      (selx),
    .selx1     (selx1),
    .selx2     (selx2),
    .haddr1    (haddr1),
    .haddr2    (haddr2),
    .hwdata1   (hwdata1),
    .hwdata2   (unused_hwdata2),
    .hwritereg (hwritereg)
  );

  assign Hrdata = Prdata;
  assign Hresp  = HRESP_OKAY;

  // Next-state: SETUP/ENABLE sequencing with a pipelined path for back-to-back writes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (valid) state_d = Hwrite ? StWwait : StRead;
      end
      StWwait:  state_d = valid ? StWritep : StWrite;
      StRead:   state_d = StRenable;
      StWrite:  state_d = valid ? StWenablep : StWenable;
      StWritep: state_d = StWenablep;
      StRenable, StWenable: begin
        if (valid) state_d = Hwrite ? StWwait : StRead;
        else       state_d = StIdle;
      end
      StWenablep: begin
        if (!hwritereg) state_d = StRead;
        else if (valid) state_d = StWritep;
        else            state_d = StWrite;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output values are chosen by the state being entered; unlisted fields hold.
  always_comb begin
    pselx_d     = Pselx;
    paddr_d     = Paddr;
    pwdata_d    = Pwdata;
    pwrite_d    = Pwrite;
    penable_d   = Penable;
    hreadyout_d = Hreadyout;
    case (state_d)
      StRead: begin
        pselx_d     = selx;
        paddr_d     = Haddr;
        pwrite_d    = 1'b0;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      StWrite, StWritep: begin
        // A second pipelined write sits one stage deeper than a fresh one.
        if (state_q == StWenablep && state_d == StWritep) begin
          pselx_d  = selx2;
          paddr_d  = haddr2;
          pwdata_d = hwdata1;
        end else begin
          pselx_d  = selx1;
          paddr_d  = haddr1;
          pwdata_d = Hwdata;
        end
        pwrite_d    = 1'b1;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      StRenable, StWenable, StWenablep: begin
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
      end
      default: begin // StIdle, StWwait
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        pwrite_d    = 1'b0;
        hreadyout_d = 1'b1;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q   <= StIdle;
      Pselx     <= '0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Hreadyout <= 1'b1;
    end else begin
      state_q   <= state_d;
      Pselx     <= pselx_d;
      Paddr     <= paddr_d;
      Pwdata    <= pwdata_d;
      Pwrite    <= pwrite_d;
      Penable   <= penable_d;
      Hreadyout <= hreadyout_d;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench: literal per-cycle expectations plus an APB protocol/transaction
// monitor fed by a queue of the accesses each stimulus is expected to produce.
module tb_ahb_apb_bridge;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b1;
  logic [1:0]  Htrans = 2'b00;
  logic [31:0] Haddr = '0;
  logic [31:0] Hwdata = '0;
  logic [31:0] Prdata = '0;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pwrite;
  logic        Penable;
  logic [2:0]  Pselx;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [2:0]  sel;
  } txn_t;
  txn_t exp_q[$];

  ahb_apb_bridge dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Haddr     (Haddr),
    .Hwdata    (Hwdata),
    .Prdata    (Prdata),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Pwrite    (Pwrite),
    .Penable   (Penable),
    .Pselx     (Pselx)
  );

  always #5 Hclk = ~Hclk;

  // Address map as a table of 64 MiB windows starting at 0x8000_0000.
  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    logic [31:0] off;
    if (a < 32'h8000_0000) return 3'b000;
    off = a - 32'h8000_0000;
    if (off < 32'h0400_0000) return 3'b001;
    if (off < 32'h0800_0000) return 3'b010;
    if (off < 32'h0C00_0000) return 3'b100;
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  // Monitor: APB handshake rules and ordered access contents, every cycle.
  logic [2:0]  prev_sel = '0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic        prev_wr = 1'b0;
  logic        prev_en = 1'b0;

  always @(negedge Hclk) begin
    txn_t t;
    chk("mon_hresp", 32'(Hresp), 32'd0);
    chk("mon_hrdata", Hrdata, Prdata);
    chk("mon_onehot", 32'($countones(Pselx) <= 1), 32'd1);
    if (Pselx != 3'b000 && !Penable) chk("mon_setup_stall", 32'(Hreadyout), 32'd0);
    if (Penable) begin
      chk("mon_en_sel", 32'(Pselx != 3'b000), 32'd1);
      chk("mon_en_after_setup",
          32'(!prev_en && prev_sel == Pselx && prev_addr == Paddr && prev_wr == Pwrite &&
              (!Pwrite || prev_wdata == Pwdata)), 32'd1);
      chk("mon_en_ready", 32'(Hreadyout), 32'd1);
      chk("mon_expected_access", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        chk("mon_acc_addr", Paddr, t.addr);
        chk("mon_acc_sel", 32'(Pselx), 32'(t.sel));
        chk("mon_acc_dir", 32'(Pwrite), 32'(t.wr));
        if (t.wr) chk("mon_acc_wdata", Pwdata, t.data);
      end
    end
    prev_sel   = Pselx;
    prev_addr  = Paddr;
    prev_wdata = Pwdata;
    prev_wr    = Pwrite;
    prev_en    = Penable;
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] sel_lit);
    Htrans = 2'b10; Hwrite = 1'b1; Haddr = addr;
    exp_q.push_back('{addr: addr, data: data, wr: 1'b1, sel: ref_sel(addr)});
    tick();  // address sampled -> WWAIT
    chk("wr_wait_sel", 32'(Pselx), 32'd0);
    chk("wr_wait_ready", 32'(Hreadyout), 32'd1);
    Htrans = 2'b00; Haddr = '0; Hwdata = data;
    tick();  // SETUP
    chk("wr_setup_sel", 32'(Pselx), 32'(sel_lit));
    chk("wr_setup_addr", Paddr, addr);
    chk("wr_setup_data", Pwdata, data);
    chk("wr_setup_dir", 32'(Pwrite), 32'd1);
    chk("wr_setup_en", 32'(Penable), 32'd0);
    chk("wr_setup_ready", 32'(Hreadyout), 32'd0);
    tick();  // ENABLE
    chk("wr_enable_en", 32'(Penable), 32'd1);
    chk("wr_enable_addr", Paddr, addr);
    tick();  // back to IDLE
    chk("wr_done_sel", 32'(Pselx), 32'd0);
    chk("wr_done_en", 32'(Penable), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [2:0] sel_lit);
    Htrans = 2'b10; Hwrite = 1'b0; Haddr = addr;
    exp_q.push_back('{addr: addr, data: 32'd0, wr: 1'b0, sel: ref_sel(addr)});
    tick();  // SETUP
    Htrans = 2'b00; Haddr = '0; Prdata = rdata;
    chk("rd_setup_sel", 32'(Pselx), 32'(sel_lit));
    chk("rd_setup_addr", Paddr, addr);
    chk("rd_setup_dir", 32'(Pwrite), 32'd0);
    chk("rd_setup_en", 32'(Penable), 32'd0);
    chk("rd_setup_ready", 32'(Hreadyout), 32'd0);
    tick();  // ENABLE
    chk("rd_enable_en", 32'(Penable), 32'd1);
    chk("rd_enable_ready", 32'(Hreadyout), 32'd1);
    chk("rd_enable_hrdata", Hrdata, rdata);
    tick();
    chk("rd_done_sel", 32'(Pselx), 32'd0);
    Prdata = '0;
  endtask

  task automatic do_ignored(input logic [1:0] tr, input logic [31:0] addr, input logic wr,
                            input logic rdy);
    Htrans = tr; Hwrite = wr; Haddr = addr; Hreadyin = rdy; Hwdata = 32'h5A5A_5A5A;
    tick();
    Htrans = 2'b00; Haddr = '0; Hreadyin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ign_sel", 32'(Pselx), 32'd0);
      chk("ign_ready", 32'(Hreadyout), 32'd1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_sel", 32'(Pselx), 32'd0);
    chk("rst_addr", Paddr, 32'd0);
    chk("rst_wdata", Pwdata, 32'd0);
    chk("rst_dir", 32'(Pwrite), 32'd0);
    chk("rst_en", 32'(Penable), 32'd0);
    chk("rst_ready", 32'(Hreadyout), 32'd1);
    Hresetn = 1'b1;
    tick();
    chk("post_rst_sel", 32'(Pselx), 32'd0);

    // Single accesses and decode
    do_write(32'h8000_0001, 32'h0000_00A3, 3'b001);
    do_read(32'h8000_00A2, 32'hDEAD_BEEF, 3'b001);
    do_read(32'h8400_0010, 32'h1234_5678, 3'b010);
    do_write(32'h8800_0010, 32'hCAFE_0001, 3'b100);
    do_write(32'h83FF_FFFF, 32'h0BAD_F00D, 3'b001);
    do_read(32'h8BFF_FFFC, 32'h0F0F_0F0F, 3'b100);

    // Transfers that must produce no APB activity
    do_ignored(2'b10, 32'h9000_0000, 1'b1, 1'b1);
    do_ignored(2'b00, 32'h8000_0000, 1'b0, 1'b1);
    do_ignored(2'b01, 32'h8000_0000, 1'b1, 1'b1);
    do_ignored(2'b10, 32'h8C00_0000, 1'b0, 1'b1);
    do_ignored(2'b11, 32'h7FFF_FFFC, 1'b1, 1'b1);
    do_ignored(2'b10, 32'h8000_0000, 1'b0, 1'b0);

    // Back-to-back writes
    Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8000_0004;
    exp_q.push_back('{addr: 32'h8000_0004, data: 32'h0000_1111, wr: 1'b1, sel: 3'b001});
    tick();
    Htrans = 2'b11; Haddr = 32'h8000_0008; Hwdata = 32'h0000_1111;
    exp_q.push_back('{addr: 32'h8000_0008, data: 32'h0000_2222, wr: 1'b1, sel: 3'b001});
    tick();
    chk("b2b_s1_addr", Paddr, 32'h8000_0004);
    chk("b2b_s1_data", Pwdata, 32'h0000_1111);
    chk("b2b_s1_en", 32'(Penable), 32'd0);
    chk("b2b_s1_ready", 32'(Hreadyout), 32'd0);
    tick();
    chk("b2b_e1_en", 32'(Penable), 32'd1);
    chk("b2b_e1_addr", Paddr, 32'h8000_0004);
    Htrans = 2'b00; Haddr = '0; Hwdata = 32'h0000_2222;
    tick();
    chk("b2b_s2_addr", Paddr, 32'h8000_0008);
    chk("b2b_s2_data", Pwdata, 32'h0000_2222);
    chk("b2b_s2_en", 32'(Penable), 32'd0);
    tick();
    chk("b2b_e2_en", 32'(Penable), 32'd1);
    chk("b2b_e2_addr", Paddr, 32'h8000_0008);
    tick();
    chk("b2b_done_sel", 32'(Pselx), 32'd0);

    // Reset during a write SETUP abandons it
    Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8000_0010;
    tick();
    Htrans = 2'b00; Haddr = '0; Hwdata = 32'h0000_0055;
    tick();
    chk("mid_rst_setup_sel", 32'(Pselx), 32'd1);
    Hresetn = 1'b0;
    tick();
    chk("mid_rst_sel", 32'(Pselx), 32'd0);
    chk("mid_rst_addr", Paddr, 32'd0);
    chk("mid_rst_wdata", Pwdata, 32'd0);
    chk("mid_rst_dir", 32'(Pwrite), 32'd0);
    chk("mid_rst_en", 32'(Penable), 32'd0);
    chk("mid_rst_ready", 32'(Hreadyout), 32'd1);
    Hresetn = 1'b1;
    tick();
    do_read(32'h8000_0020, 32'hA5A5_0001, 3'b001);

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-to-APB bridge that sits directly downstream of the AHB master and consumes its address-phase and data-phase signals. It pipelines each AHB transfer, decodes it to one of three APB peripheral selects and runs the two-phase APB SETUP/ENABLE sequence. It returns Hreadyout, Hresp and Hrdata to the master and supports back-to-back writes through a pipelined write path.

## Interface
- No parameters. The address map and codes are constants in the shared package.
- Hclk  in  1  single clock; all state updates on its rising edge
- Hresetn  in  1  synchronous, active-low reset
- Hwrite  in  1  1 = write, 0 = read (address phase)
- Hreadyin  in  1  AHB ready from master/bus; transfer sampled only when 1
- Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- Haddr  in  32  address-phase address
- Hwdata  in  32  data-phase write data
- Prdata  in  32  APB read data
- Hreadyout  out  1  0 stalls the master
- Hresp  out  2  constant 2'b00 (OKAY)
- Hrdata  out  32  combinational copy of Prdata
- Paddr  out  32  APB address
- Pwdata  out  32  APB write data
- Pwrite  out  1  APB direction
- Penable  out  1  APB ENABLE phase
- Pselx  out  3  one-hot peripheral select

## Operation
- valid = Hreadyin & (Htrans==10 | Htrans==11) & (32'h8000_0000 <= Haddr < 32'h8C00_0000). Combinational.
- selx decode:
  - 8000_0000–83FF_FFFF → 001
  - 8400_0000–87FF_FFFF → 010
  - 8800_0000–8BFF_FFFF → 100
  - otherwise → 000
- Pipeline registers are loaded every edge: Haddr1←Haddr, Haddr2←Haddr1, Hwdata1←Hwdata, Hwdata2←Hwdata1, Hwritereg←Hwrite.
- FSM states and transitions (a transition with no condition is taken every edge):
  - IDLE: valid&Hwrite→WWAIT; valid&!Hwrite→READ; else IDLE.
  - WWAIT: valid→WRITEP; else WRITE.
  - READ: →RENABLE.
  - WRITE: valid→WENABLEP; else WENABLE.
  - WRITEP: →WENABLEP.
  - RENABLE, WENABLE: valid&!Hwrite→READ; valid&Hwrite→WWAIT; else IDLE.
  - WENABLEP: !Hwritereg→READ; valid&Hwritereg→WRITEP; else WRITE.
- Output values loaded on entry to each state:
  - READ: Pselx=selx(Haddr), Paddr=Haddr, Pwrite=0, Penable=0, Hreadyout=0.
  - WRITE/WRITEP: Pselx=selx(Haddr1), Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Penable=0, Hreadyout=0.
  - Entering WRITEP from WENABLEP uses Haddr2/Hwdata1 instead.
  - RENABLE/WENABLE/WENABLEP: hold Paddr/Pwdata/Pwrite/Pselx, Penable=1, Hreadyout=1.
  - IDLE/WWAIT: Pselx=0, Penable=0, Pwrite=0, Hreadyout=1. Paddr/Pwdata hold.
- Invalid transfers (IDLE/BUSY Htrans, out-of-map address, Hreadyin=0) are ignored: no APB activity and Hresp stays OKAY.

## Timing
- Reset (Hresetn=0 at an edge):
  - state=IDLE
  - Paddr, Pwdata, Pwrite, Penable, Pselx = 0
  - Hreadyout=1
  - pipeline registers = 0
- A reset mid-transfer abandons the transfer; outputs are at reset values after that edge.
- All APB outputs and Hreadyout are registered, changing only at Hclk edges. Hrdata and Hresp are combinational.
- Single write (address phase sampled at edge E1):
  - E1: →WWAIT.
  - E2: →WRITE; Pselx, Paddr and Pwdata (the data-phase Hwdata) valid; Penable=0.
  - E3: →WENABLE; Penable=1.
  - E4: →IDLE; Pselx=0.
- Single read (address phase sampled at E1):
  - E1: →READ; SETUP phase.
  - E2: →RENABLE; Penable=1, Hreadyout=1, Hrdata=Prdata for that cycle.
  - E3: →IDLE.
- The master must hold its address phase while Hreadyout=0.
- Pselx and Paddr are stable from SETUP through ENABLE. Penable is never 1 in the first cycle of a select.

## Structure
- Package ahb_apb_pkg:
  - FSM state enum (8 states)
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY
  - the three region base/limit constants
- Sub-module ahb_slave_if contains the pipeline registers, valid and selx decode.
- The top-level ahb_apb_bridge contains the FSM and the output registers.

## Test plan
- Single write, Haddr=8000_0001, Hwdata=A3:
  - edge after data phase: Pselx=001, Paddr=8000_0001, Pwdata=A3, Pwrite=1, Penable=0;
  - next edge: Penable=1;
  - next edge: Pselx=0.
- Single read, Haddr=8000_00A2, Prdata=DEAD_BEEF:
  - SETUP: Pselx=001, Pwrite=0, Hreadyout=0;
  - ENABLE: Penable=1, Hreadyout=1, Hrdata=DEAD_BEEF.
- Decode of Haddr=8400_0010 → Pselx=010 and Haddr=8800_0010 → Pselx=100. Haddr=9000_0000 or Htrans=00 → no Pselx assertion in any cycle.
- Back-to-back writes to 8000_0004 and 8000_0008: two SETUP/ENABLE pairs via WRITEP/WENABLEP, with addresses and data in issue order.
- Hresetn=0 in a WRITE cycle → at the next edge all P* outputs are 0, Hreadyout=1, and the FSM is IDLE. A subsequent read completes normally.
